wb_stat_ctrl: RTL
=================

// Module: wb_stat_ctrl
// PURPOSE
//  Per-frame white-balance statistics controller, downstream of the bayer colour-flag selector.
//  Sequences R/G/B channel accumulation inside a programmable ROI window, once per frame.
//  Latches the sums at frame end and holds them until the gain-calc/register side acknowledges.
//  Only starts accumulating on a clean frame start; never starts mid-frame.
// PARAMETERS
//  SENSOR_DAT_WIDTH  10  pixel data width
//  WIN_WIDTH         16  width of ROI offset/size and of internal x/y counters
//  SUM_WIDTH         32  width of each colour accumulator (saturating)
// PORTS
//  clk            in   1                 pixel clock; single clock domain
//  reset_n        in   1                 synchronous reset, active low
//  i_stat_en      in   1                 statistics enable
//  iv_offset_x    in   WIN_WIDTH         ROI first column (pixels from lval rise)
//  iv_offset_y    in   WIN_WIDTH         ROI first line (lines from fval rise)
//  iv_width       in   WIN_WIDTH         ROI width in pixels; 0 = empty window
//  iv_height      in   WIN_WIDTH         ROI height in lines; 0 = empty window
//  i_fval         in   1                 frame valid (aligned with flags/data)
//  i_lval         in   1                 line valid
//  i_r_flag       in   1                 current pixel is R
//  i_g_flag       in   1                 current pixel is G
//  i_b_flag       in   1                 current pixel is B
//  iv_pix_data    in   SENSOR_DAT_WIDTH  pixel value
//  o_stat_valid   out  1                 latched results valid; held until ack
//  i_stat_ack     in   1                 result consumed (sampled only while o_stat_valid=1)
//  ov_r_sum       out  SUM_WIDTH         R sum of last completed frame
//  ov_g_sum       out  SUM_WIDTH         G sum
//  ov_b_sum       out  SUM_WIDTH         B sum
//  o_busy         out  1                 1 in ACCUM state
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=SYNC; all outputs, accumulators and counters = 0.
//  Edges: fval_rise = i_fval & ~fval_dly; fval_fall = ~i_fval & fval_dly; lval_fall likewise.
//  FSM:
//   SYNC:  go to WAIT when i_fval=0 and i_stat_en=1.
//   WAIT:  on fval_rise, sample offset/width/height into shadow regs, clear sums and y_cnt,
//          go to ACCUM. The fval_rise cycle itself is accumulated.
//   ACCUM: accumulate. On fval_fall, copy sums to outputs, assert o_stat_valid next cycle, go to DONE.
//   DONE:  hold outputs. When i_stat_ack=1, drop o_stat_valid next cycle and go to SYNC.
//  i_stat_en=0: SYNC/WAIT/ACCUM return to SYNC next cycle and discard the partial frame.
//   DONE ignores enable and still waits for ack.
//  Frames that start while in DONE or SYNC are skipped entirely; there is no partial-frame capture.
//  Counters:
//   x_cnt: 0 while i_lval=0; increments each i_lval=1 cycle (first pixel x=0).
//   y_cnt: increments on lval_fall; cleared on fval_rise (first line y=0).
//  In-window test: offset_x <= x < offset_x+width and offset_y <= y < offset_y+height.
//   Compute in WIN_WIDTH+1 bits so the window end cannot wrap.
//  Accumulate when i_fval & i_lval & in-window: sum += zero-extended iv_pix_data, into the
//   channel whose flag is set. If no flag is set, add nothing.
//  Multiple flags set at once (illegal) -> priority R > G > B.
//  Saturation: a sum that would exceed 2^SUM_WIDTH-1 sticks at all-ones for the rest of the frame.
//  Shadow config changes take effect only at the next fval_rise accepted in WAIT.
//  Latency: o_stat_valid rises exactly 2 clk after the last i_fval=1 sample.
//   (fval_fall is seen 1 cycle after that sample; outputs are registered.)
//  Output sums stay stable for the whole time o_stat_valid=1.
//  Reset mid-frame: returns to SYNC. Accumulation resumes at the first fval_rise after i_fval=0.
// TESTING
//  1 GR-pattern 4x4 frame, ROI 0,0,4,4, all pixels=1 -> r=4,g=8,b=4; valid 2 clk after fval low.
//  2 ROI x=1,y=1,w=2,h=2, pixel=x+10*y -> sums equal the hand-computed values for the 4 inner pixels only.
//  3 pixels=1023, SUM_WIDTH=12, 64 G pixels -> g_sum=4095 (saturated), r/b unaffected.
//  4 Hold ack low across 2 frames -> sums unchanged, 2nd frame skipped; after ack, 3rd frame captured.
//  5 Enable/reset while fval=1 mid-frame -> SYNC; that frame gives no valid; next full frame correct.
//  6 Width=0 or height=0 -> valid asserted with all sums=0; ack in the same cycle valid rises is honoured.

Source files
------------

// File: rtl/wb_stat_ctrl_if.sv
// Bus bundle for wb_stat_ctrl: pixel stream with colour flags, ROI configuration,
// and the latched-result handshake towards the gain-calc side.
interface wb_stat_ctrl_if #(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int WIN_WIDTH        = 16,
   parameter int SUM_WIDTH        = 32
);
   logic                        i_stat_en;
   logic [WIN_WIDTH-1:0]        iv_offset_x;
   logic [WIN_WIDTH-1:0]        iv_offset_y;
   logic [WIN_WIDTH-1:0]        iv_width;
   logic [WIN_WIDTH-1:0]        iv_height;
   logic                        i_fval;
   logic                        i_lval;
   logic                        i_r_flag;
   logic                        i_g_flag;
   logic                        i_b_flag;
   logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data;
   logic                        o_stat_valid;
   logic                        i_stat_ack;
   logic [SUM_WIDTH-1:0]        ov_r_sum;
   logic [SUM_WIDTH-1:0]        ov_g_sum;
   logic [SUM_WIDTH-1:0]        ov_b_sum;
   logic                        o_busy;

   modport master (
      output i_stat_en, iv_offset_x, iv_offset_y, iv_width, iv_height,
             i_fval, i_lval, i_r_flag, i_g_flag, i_b_flag, iv_pix_data, i_stat_ack,
      input  o_stat_valid, ov_r_sum, ov_g_sum, ov_b_sum, o_busy
   );

   modport slave (
      input  i_stat_en, iv_offset_x, iv_offset_y, iv_width, iv_height,
             i_fval, i_lval, i_r_flag, i_g_flag, i_b_flag, iv_pix_data, i_stat_ack,
      output o_stat_valid, ov_r_sum, ov_g_sum, ov_b_sum, o_busy
   );
endinterface

// File: rtl/wb_stat_ctrl.sv
// Per-frame white-balance statistics: saturating R/G/B sums over a programmable ROI,
// captured only from clean frame starts and held until acknowledged.
module wb_stat_ctrl #(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int WIN_WIDTH        = 16,
   parameter int SUM_WIDTH        = 32
) (
   input logic           clk,
   input logic           reset_n,
   wb_stat_ctrl_if.slave bus
);

   typedef enum logic [1:0] {ST_SYNC, ST_WAIT, ST_ACCUM, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic                  fval_dly_q, lval_dly_q;
   logic [WIN_WIDTH-1:0]  x_cnt_q, x_cnt_d;
   logic [WIN_WIDTH-1:0]  y_cnt_q, y_cnt_d;
   logic [WIN_WIDTH-1:0]  off_x_q, off_x_d, off_y_q, off_y_d;
   logic [WIN_WIDTH-1:0]  width_q, width_d, height_q, height_d;
   logic [SUM_WIDTH-1:0]  r_acc_q, r_acc_d, g_acc_q, g_acc_d, b_acc_q, b_acc_d;
   logic [SUM_WIDTH-1:0]  r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;
   logic                  valid_q, valid_d;

   logic                  fval_rise, fval_fall, lval_fall;
   logic                  frame_start, acc_en, in_win;
   logic [WIN_WIDTH-1:0]  cfg_off_x, cfg_off_y, cfg_width, cfg_height, y_pix;
   logic [WIN_WIDTH:0]    x_pos, y_pos, x_lo, x_hi, y_lo, y_hi;
   logic [SUM_WIDTH-1:0]  r_base, g_base, b_base, r_new, g_new, b_new;

   function automatic logic [SUM_WIDTH-1:0] sat_add(
      input logic [SUM_WIDTH-1:0]        acc,
      input logic [SENSOR_DAT_WIDTH-1:0] pix
   );
      logic [SUM_WIDTH:0] s;
      s = {1'b0, acc} + {{(SUM_WIDTH + 1 - SENSOR_DAT_WIDTH){1'b0}}, pix};
      return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
   endfunction

   assign fval_rise   = bus.i_fval & ~fval_dly_q;
   assign fval_fall   = ~bus.i_fval & fval_dly_q;
   assign lval_fall   = ~bus.i_lval & lval_dly_q;
   assign frame_start = (state_q == ST_WAIT) & bus.i_stat_en & fval_rise;

   always_comb begin
      x_cnt_d = bus.i_lval ? x_cnt_q + 1'b1 : '0;
      y_cnt_d = y_cnt_q;
      if (fval_rise) begin
         y_cnt_d = '0;
      end else if (lval_fall) begin
         y_cnt_d = y_cnt_q + 1'b1;
      end
   end

   // The frame-start pixel is judged against the live config and line 0,
   // since the shadow registers and y counter only update at the end of that cycle.
   always_comb begin
      cfg_off_x  = frame_start ? bus.iv_offset_x : off_x_q;
      cfg_off_y  = frame_start ? bus.iv_offset_y : off_y_q;
      cfg_width  = frame_start ? bus.iv_width    : width_q;
      cfg_height = frame_start ? bus.iv_height   : height_q;
      y_pix      = fval_rise ? '0 : y_cnt_q;
      x_pos      = {1'b0, x_cnt_q};
      y_pos      = {1'b0, y_pix};
      x_lo       = {1'b0, cfg_off_x};
      y_lo       = {1'b0, cfg_off_y};
      x_hi       = {1'b0, cfg_off_x} + {1'b0, cfg_width};
      y_hi       = {1'b0, cfg_off_y} + {1'b0, cfg_height};
      in_win     = (x_pos >= x_lo) && (x_pos < x_hi) && (y_pos >= y_lo) && (y_pos < y_hi);
      acc_en     = (frame_start | (state_q == ST_ACCUM)) & bus.i_fval & bus.i_lval & in_win;
   end

   always_comb begin
      r_base = frame_start ? '0 : r_acc_q;
      g_base = frame_start ? '0 : g_acc_q;
      b_base = frame_start ? '0 : b_acc_q;
      r_new  = r_base;
      g_new  = g_base;
      b_new  = b_base;
      if (acc_en) begin
         if (bus.i_r_flag) begin
            r_new = sat_add(r_base, bus.iv_pix_data);
         end else if (bus.i_g_flag) begin
            g_new = sat_add(g_base, bus.iv_pix_data);
         end else if (bus.i_b_flag) begin
            b_new = sat_add(b_base, bus.iv_pix_data);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      off_x_d  = off_x_q;
      off_y_d  = off_y_q;
      width_d  = width_q;
      height_d = height_q;
      r_acc_d  = r_acc_q;
      g_acc_d  = g_acc_q;
      b_acc_d  = b_acc_q;
      r_out_d  = r_out_q;
      g_out_d  = g_out_q;
      b_out_d  = b_out_q;
      case (state_q)
         ST_SYNC: begin
            if (bus.i_stat_en && !bus.i_fval) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.i_stat_en) begin
               state_d = ST_SYNC;
            end else if (fval_rise) begin
               state_d  = ST_ACCUM;
               off_x_d  = bus.iv_offset_x;
               off_y_d  = bus.iv_offset_y;
               width_d  = bus.iv_width;
               height_d = bus.iv_height;
               r_acc_d  = r_new;
               g_acc_d  = g_new;
               b_acc_d  = b_new;
            end
         end
         ST_ACCUM: begin
            if (!bus.i_stat_en) begin
               state_d = ST_SYNC;
            end else begin
               r_acc_d = r_new;
               g_acc_d = g_new;
               b_acc_d = b_new;
               if (fval_fall) begin
                  state_d = ST_DONE;
                  r_out_d = r_acc_q;
                  g_out_d = g_acc_q;
                  b_out_d = b_acc_q;
               end
            end
         end
         ST_DONE: begin
            // Valid comes up one cycle after entering DONE; ack is only honoured once it is visible.
            if (valid_q && bus.i_stat_ack) begin
               valid_d = 1'b0;
               state_d = ST_SYNC;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_SYNC;
         fval_dly_q <= 1'b0;
         lval_dly_q <= 1'b0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         off_x_q    <= '0;
         off_y_q    <= '0;
         width_q    <= '0;
         height_q   <= '0;
         r_acc_q    <= '0;
         g_acc_q    <= '0;
         b_acc_q    <= '0;
         r_out_q    <= '0;
         g_out_q    <= '0;
         b_out_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fval_dly_q <= bus.i_fval;
         lval_dly_q <= bus.i_lval;
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
         off_x_q    <= off_x_d;
         off_y_q    <= off_y_d;
         width_q    <= width_d;
         height_q   <= height_d;
         r_acc_q    <= r_acc_d;
         g_acc_q    <= g_acc_d;
         b_acc_q    <= b_acc_d;
         r_out_q    <= r_out_d;
         g_out_q    <= g_out_d;
         b_out_q    <= b_out_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.o_stat_valid = valid_q;
   assign bus.ov_r_sum     = r_out_q;
   assign bus.ov_g_sum     = g_out_q;
   assign bus.ov_b_sum     = b_out_q;
   assign bus.o_busy       = (state_q == ST_ACCUM);

endmodule
